// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants and FSM state type for the 16-way round-robin arbiter
package arb_pkg;

    localparam int N_REQ       = 16;
    localparam int ID_W        = 4;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/prio_enc16.sv
// rtl/prio_enc16.sv - 16-bit lowest-index-first priority encoder
module prio_enc16
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] in,
    output logic [ID_W-1:0]  idx,
    output logic             valid
);

    // Scan from the top down so the lowest set bit is the last to win
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (in[i]) begin
                idx   = ID_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arb16.sv
// rtl/rr_arb16.sv - 16-requester round-robin arbiter; optional hold timeout via RR_ARB16_TIMEOUT_EN
module rr_arb16
    import arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             E,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid,
    output logic             timeout
);

    state_t              state;
    logic [ID_W-1:0]     ptr;
    logic [2*N_REQ-1:0]  req_shift;
    logic [N_REQ-1:0]    req_rot;
    logic [ID_W-1:0]     enc_idx;
    logic                enc_valid;
    logic [ID_W-1:0]     sel_id;
    logic                owner_release;
    logic                force_release;

    // Rotate right by ptr so the search always starts at index 0 of the encoder
    always_comb begin
        req_shift = {req, req} >> ptr;
        req_rot   = req_shift[N_REQ-1:0];
    end

    prio_enc16 u_prio_enc16 (
        .in    (req_rot),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    // Undo the rotation; 4-bit addition wraps mod 16 naturally
    always_comb begin
        sel_id        = enc_idx + ptr;
        owner_release = done | ~req[gnt_id];
    end

`ifdef RR_ARB16_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(TIMEOUT - 1);

    logic [7:0] hold_cnt;
    logic       timeout_q;

    always_comb begin
        force_release = (state == GRANT) && (hold_cnt == HOLD_LAST);
    end

    // Hold counter sits at zero in IDLE so it is cleared on entry to GRANT;
    // timeout pulses only when the forced release is not also a normal release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == GRANT && !owner_release && !force_release) begin
                hold_cnt <= hold_cnt + 8'd1;
            end else begin
                hold_cnt <= '0;
            end
            timeout_q <= force_release & ~owner_release;
        end
    end

    assign timeout = timeout_q;
`else
    assign force_release = 1'b0;
    assign timeout       = 1'b0;
`endif

    // Arbitration FSM with registered grant outputs; gnt_id is kept across IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (E && enc_valid) begin
                        state     <= GRANT;
                        gnt       <= N_REQ'(1) << sel_id;
                        gnt_id    <= sel_id;
                        gnt_valid <= 1'b1;
                    end else begin
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                    end
                end
                GRANT: begin
                    if (owner_release || force_release) begin
                        state     <= IDLE;
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        ptr       <= gnt_id + 4'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt       <= '0;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arb16.sv
// tb/tb_rr_arb16.sv - directed self-checking bench for rr_arb16
`timescale 1ns/1ps
module tb_rr_arb16;

    logic        clk;
    logic        rst_n;
    logic        E;
    logic [15:0] req;
    logic        done;
    logic [15:0] gnt;
    logic [3:0]  gnt_id;
    logic        gnt_valid;
    logic        timeout;

    int pass_cnt;
    int total_cnt;

    rr_arb16 #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .E         (E),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        E = 1'b1;
        req = 16'hFFFF;
        done = 1'b0;
        step();
        step();
        total_cnt++;
        if ({gnt, gnt_id, gnt_valid, timeout} !== 22'd0)
            $display("FAIL reset_outputs gnt=%h id=%0d valid=%b to=%b expected all zero", gnt, gnt_id, gnt_valid, timeout);
        else pass_cnt++;
        E = 1'b0;
        req = 16'h0000;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        E = 1'b1;
        req = 16'h0001;
        step();
        total_cnt++;
        if (gnt !== 16'h0001 || gnt_id !== 4'd0 || gnt_valid !== 1'b1)
            $display("FAIL basic_grant gnt=%h id=%0d valid=%b expected 0001/0/1", gnt, gnt_id, gnt_valid);
        else pass_cnt++;
        done = 1'b1;
        step();
        done = 1'b0;
        total_cnt++;
        if (gnt !== 16'h0000 || gnt_valid !== 1'b0)
            $display("FAIL basic_release gnt=%h valid=%b expected 0000/0", gnt, gnt_valid);
        else pass_cnt++;
        req = 16'hFFFF;
        step();
        total_cnt++;
        if (gnt_id !== 4'd1 || gnt !== 16'h0002)
            $display("FAIL basic_ptr_advance id=%0d gnt=%h expected 1/0002", gnt_id, gnt);
        else pass_cnt++;
        req = 16'h0000;
        step();
        total_cnt++;
        if (gnt_valid !== 1'b0)
            $display("FAIL basic_req_drop_release valid=%b expected 0", gnt_valid);
        else pass_cnt++;
    endtask

    task automatic test_rotation();
        int errs;
        errs = 0;
        do_reset();
        E = 1'b1;
        req = 16'hFFFF;
        for (int i = 0; i < 17; i++) begin
            step();
            if (gnt_valid !== 1'b1 || gnt_id !== 4'(i % 16) || gnt !== (16'h0001 << (i % 16))) begin
                errs++;
                $display("FAIL rotation_grant step=%0d id=%0d gnt=%h expected id %0d", i, gnt_id, gnt, i % 16);
            end
            done = 1'b1;
            step();
            done = 1'b0;
            if (gnt_valid !== 1'b0 || gnt !== 16'h0000) begin
                errs++;
                $display("FAIL rotation_idle_gap step=%0d gnt=%h valid=%b expected 0000/0", i, gnt, gnt_valid);
            end
        end
        total_cnt++;
        if (errs == 0) pass_cnt++;
        req = 16'h0000;
    endtask

    task automatic test_wrap();
        // ptr is 1 here; grant 13 and release to leave ptr=14
        E = 1'b1;
        req = 16'h2000;
        step();
        total_cnt++;
        if (gnt_id !== 4'd13)
            $display("FAIL wrap_setup id=%0d expected 13", gnt_id);
        else pass_cnt++;
        done = 1'b1;
        step();
        done = 1'b0;
        req = 16'h0009;
        step();
        total_cnt++;
        if (gnt_id !== 4'd0 || gnt !== 16'h0001)
            $display("FAIL wrap_first id=%0d gnt=%h expected 0/0001", gnt_id, gnt);
        else pass_cnt++;
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        total_cnt++;
        if (gnt_id !== 4'd3 || gnt !== 16'h0008)
            $display("FAIL wrap_second id=%0d gnt=%h expected 3/0008", gnt_id, gnt);
        else pass_cnt++;
        done = 1'b1;
        step();
        done = 1'b0;
        req = 16'h0000;
    endtask

    task automatic test_hold();
        int errs;
        // ptr is 4 here
        E = 1'b1;
        req = 16'h0020;
        step();
        total_cnt++;
        if (gnt_id !== 4'd5 || gnt !== 16'h0020)
            $display("FAIL hold_grant id=%0d gnt=%h expected 5/0020", gnt_id, gnt);
        else pass_cnt++;
        errs = 0;
        E = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req = (i % 2 == 0) ? 16'hFFFF : 16'h0020;
            step();
            if (gnt !== 16'h0020 || gnt_id !== 4'd5 || gnt_valid !== 1'b1) begin
                errs++;
                $display("FAIL hold_keep cycle=%0d gnt=%h id=%0d expected 0020/5", i, gnt, gnt_id);
            end
        end
        total_cnt++;
        if (errs == 0) pass_cnt++;
        req = 16'hFFDF;
        step();
        total_cnt++;
        if (gnt !== 16'h0000 || gnt_valid !== 1'b0)
            $display("FAIL hold_req_drop gnt=%h valid=%b expected 0000/0", gnt, gnt_valid);
        else pass_cnt++;
        // E low with pending requests and a stray done: no grant, id kept
        done = 1'b1;
        step();
        step();
        done = 1'b0;
        total_cnt++;
        if (gnt !== 16'h0000 || gnt_valid !== 1'b0 || gnt_id !== 4'd5)
            $display("FAIL idle_e_low gnt=%h valid=%b id=%0d expected 0000/0/5", gnt, gnt_valid, gnt_id);
        else pass_cnt++;
        req = 16'h0000;
    endtask

    task automatic test_timeout();
        int errs;
        // ptr is 6 here; only requester 0 asks
        E = 1'b1;
        req = 16'h0001;
        step();
        total_cnt++;
        if (gnt_id !== 4'd0 || gnt_valid !== 1'b1)
            $display("FAIL timeout_grant id=%0d valid=%b expected 0/1", gnt_id, gnt_valid);
        else pass_cnt++;
        errs = 0;
`ifdef RR_ARB16_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            step();
            if (gnt !== 16'h0001 || timeout !== 1'b0) begin
                errs++;
                $display("FAIL timeout_hold cycle=%0d gnt=%h to=%b expected 0001/0", i, gnt, timeout);
            end
        end
        step();
        if (gnt !== 16'h0000 || gnt_valid !== 1'b0 || timeout !== 1'b1) begin
            errs++;
            $display("FAIL timeout_fire gnt=%h valid=%b to=%b expected 0000/0/1", gnt, gnt_valid, timeout);
        end
        step();
        if (timeout !== 1'b0 || gnt !== 16'h0001) begin
            errs++;
            $display("FAIL timeout_pulse_width to=%b gnt=%h expected 0/0001", timeout, gnt);
        end
        step();
        step();
        step();
        done = 1'b1;
        step();
        done = 1'b0;
        if (gnt !== 16'h0000 || timeout !== 1'b0) begin
            errs++;
            $display("FAIL timeout_coincide gnt=%h to=%b expected 0000/0", gnt, timeout);
        end
`else
        for (int i = 0; i < 20; i++) begin
            step();
            if (gnt !== 16'h0001 || timeout !== 1'b0) begin
                errs++;
                $display("FAIL timeout_disabled_hold cycle=%0d gnt=%h to=%b expected 0001/0", i, gnt, timeout);
            end
        end
        done = 1'b1;
        step();
        done = 1'b0;
        if (gnt !== 16'h0000) begin
            errs++;
            $display("FAIL timeout_disabled_release gnt=%h expected 0000", gnt);
        end
`endif
        total_cnt++;
        if (errs == 0) pass_cnt++;
        req = 16'h0000;
        step();
    endtask

    task automatic test_reset_mid();
        E = 1'b1;
        req = 16'h0400;
        step();
        total_cnt++;
        if (gnt !== 16'h0400 || gnt_id !== 4'd10)
            $display("FAIL reset_mid_setup gnt=%h id=%0d expected 0400/10", gnt, gnt_id);
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (gnt !== 16'h0000 || gnt_valid !== 1'b0 || gnt_id !== 4'd0)
            $display("FAIL reset_mid_async gnt=%h valid=%b id=%0d expected 0000/0/0", gnt, gnt_valid, gnt_id);
        else pass_cnt++;
        req = 16'h8001;
        #1;
        rst_n = 1'b1;
        step();
        total_cnt++;
        if (gnt_id !== 4'd0 || gnt !== 16'h0001 || gnt_valid !== 1'b1)
            $display("FAIL reset_mid_rearb id=%0d gnt=%h expected 0/0001", gnt_id, gnt);
        else pass_cnt++;
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        total_cnt++;
        if (gnt_id !== 4'd15 || gnt !== 16'h8000)
            $display("FAIL reset_mid_next id=%0d gnt=%h expected 15/8000", gnt_id, gnt);
        else pass_cnt++;
        req = 16'h0000;
        step();
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n = 1'b0;
        E     = 1'b0;
        req   = 16'h0000;
        done  = 1'b0;
        test_reset();
        test_basic();
        test_rotation();
        test_wrap();
        test_hold();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
